// File: rtl/snn_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : snn_image_loader
//  Description : Upstream feeder for snn_core. Receives a packed binary image
//                over a valid/ready byte stream. Each byte is unpacked LSB
//                first into the 1-bit input-unit RAM, one bit per clock. When
//                the last pixel has been written, the loader pulses start,
//                waits for core_done and then presents the classified digit.
//                Optional feature macro: SNN_LOADER_TIMEOUT_EN. When it is
//                defined, a partial image is discarded after TIMEOUT_CYC idle
//                clocks between bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_image_loader #(
    parameter int NUM_PIXELS  = 784,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic [3:0]        digit,
    output logic              digit_valid,
    output logic              busy
);

    // The byte index is the RAM address without its three bit-select LSBs.
    localparam int                  c_BIDX_W    = ADDR_W - 3;
    localparam logic [c_BIDX_W-1:0] c_LAST_BYTE = c_BIDX_W'(NUM_PIXELS / 8 - 1);

    typedef enum logic [1:0] {
        S_ACCEPT    = 2'd0,
        S_UNPACK    = 2'd1,
        S_START     = 2'd2,
        S_WAIT_CORE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_BIDX_W-1:0] r_byte_idx;
    logic [2:0]          r_bit_idx;
    logic [6:0]          r_shift;

    logic                r_rx_ready;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_wdata;
    logic                r_start;
    logic [3:0]          r_digit;
    logic                r_digit_valid;
    logic                r_busy;

    logic                w_accept;
    logic                w_timeout_hit;

    // r_rx_ready is only ever high while in ACCEPT, so it alone qualifies
    // the handshake.
    assign w_accept = r_rx_ready & rx_valid;

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_idle_partial;

    // Idle means waiting in ACCEPT with part of an image already stored.
    assign w_idle_partial = (r_state == S_ACCEPT) && (r_byte_idx != '0) && !w_accept;
    assign w_timeout_hit  = w_idle_partial && (r_to_cnt == c_TO_LAST);

    // Idle-gap counter: runs only on a stalled partial image, otherwise held at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_idle_partial && !w_timeout_hit) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    // Without the timeout a partial image waits forever for its remaining bytes.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout_hit    = 1'b0;
`endif

    // Main control: accept a byte, serialise it into the RAM, kick the core and
    // collect its answer. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_ACCEPT;
            r_byte_idx    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_rx_ready    <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= 1'b0;
            r_start       <= 1'b0;
            r_digit       <= '0;
            r_digit_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_start       <= 1'b0;
            r_digit_valid <= 1'b0;

            case (r_state)
                S_ACCEPT: begin
                    r_rx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_ram_we   <= 1'b0;
                    if (w_accept) begin
                        // Bit 0 goes out immediately; the rest wait in the shifter.
                        r_rx_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= {r_byte_idx, 3'b000};
                        r_ram_wdata <= rx_data[0];
                        r_shift     <= rx_data[7:1];
                        r_bit_idx   <= '0;
                        r_state     <= S_UNPACK;
                    end else if (w_timeout_hit) begin
                        r_byte_idx <= '0;
                    end
                end

                S_UNPACK: begin
                    if (r_bit_idx != 3'd7) begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_ram_addr + ADDR_W'(1);
                        r_ram_wdata <= r_shift[0];
                        r_shift     <= {1'b0, r_shift[6:1]};
                        r_bit_idx   <= r_bit_idx + 3'd1;
                    end else begin
                        // Bit 7 is on the RAM port this cycle; the byte is done.
                        r_ram_we  <= 1'b0;
                        r_bit_idx <= '0;
                        if (r_byte_idx == c_LAST_BYTE) begin
                            r_start <= 1'b1;
                            r_state <= S_START;
                        end else begin
                            r_byte_idx <= r_byte_idx + c_BIDX_W'(1);
                            r_rx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_ACCEPT;
                        end
                    end
                end

                S_START: begin
                    // start is high for this cycle only; core_done is ignored here.
                    r_ram_we <= 1'b0;
                    r_state  <= S_WAIT_CORE;
                end

                S_WAIT_CORE: begin
                    if (core_done) begin
                        r_digit       <= core_digit;
                        r_digit_valid <= 1'b1;
                        r_byte_idx    <= '0;
                        r_bit_idx     <= '0;
                        r_rx_ready    <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_ACCEPT;
                    end
                end

                default: begin
                    r_state <= S_ACCEPT;
                end
            endcase
        end
    end

    assign rx_ready    = r_rx_ready;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign start       = r_start;
    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_snn_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_image_loader
//  Description : Self-checking bench for snn_image_loader. A queue-based
//                reference model predicts every output on every cycle from the
//                byte stream and core responses; literal pins anchor the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_image_loader;

    localparam int c_NPIX   = 784;
    localparam int c_NBYTES = c_NPIX / 8;
    localparam int c_TO     = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_wdata;
    logic       start;
    logic       core_done;
    logic [3:0] core_digit;
    logic [3:0] digit;
    logic       digit_valid;
    logic       busy;

    always #5 clk = ~clk;

    snn_image_loader #(
        .NUM_PIXELS (c_NPIX),
        .ADDR_W     (10),
        .TIMEOUT_CYC(c_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .start      (start),
        .core_done  (core_done),
        .core_digit (core_digit),
        .digit      (digit),
        .digit_valid(digit_valid),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Expected outputs for the current cycle.
    logic       e_ready = 0, e_busy = 0, e_we = 0, e_wdata = 0, e_start = 0, e_dv = 0;
    logic       e_rstc = 1;
    int         e_addr = 0;
    logic [3:0] e_digit = 0;
    // Pending pixel writes, one emitted per cycle.
    int   q_addr[$];
    bit   q_data[$];
    int   m_byte = 0;
    bit   m_last_pending = 0;
    bit   m_waiting = 0;
    int   m_idle = 0;

    // Observations for literal pins.
    int   starts_seen = 0, dv_seen = 0, hs_seen = 0;
    int   wlog_a[$];
    bit   wlog_d[$];

    // Compare outputs, then advance the model using inputs for the coming edge.
    always @(negedge clk) begin
        chk("rx_ready", 32'(rx_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("start", 32'(start), 32'(e_start));
        chk("digit_valid", 32'(digit_valid), 32'(e_dv));
        chk("digit", 32'(digit), 32'(e_digit));
        if (e_we || e_rstc) begin
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        end
        if (start === 1'b1) starts_seen++;
        if (digit_valid === 1'b1) dv_seen++;
        if (rx_valid && rx_ready === 1'b1) hs_seen++;
        if (ram_we === 1'b1) begin
            wlog_a.push_back(int'(ram_addr));
            wlog_d.push_back(ram_wdata);
        end

        if (rst) begin
            e_ready = 0; e_busy = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_start = 0; e_dv = 0; e_digit = 0; e_rstc = 1;
            q_addr.delete(); q_data.delete();
            m_byte = 0; m_last_pending = 0; m_waiting = 0; m_idle = 0;
        end else begin
            logic n_ready, n_we, n_start, n_dv;
            n_ready = e_ready; n_we = 0; n_start = 0; n_dv = 0;
            if (e_rstc) begin
                n_ready = 1;
            end else begin
`ifdef SNN_LOADER_TIMEOUT_EN
                if (e_ready && !rx_valid && m_byte != 0) begin
                    m_idle++;
                    if (m_idle == c_TO) begin m_byte = 0; m_idle = 0; end
                end else begin
                    m_idle = 0;
                end
`endif
                if (e_ready && rx_valid) begin
                    for (int i = 0; i < 8; i++) begin
                        q_addr.push_back(m_byte * 8 + i);
                        q_data.push_back(rx_data[i]);
                    end
                    m_last_pending = (m_byte == c_NBYTES - 1);
                    m_byte++;
                    n_ready = 0;
                end
                if (q_addr.size() > 0) begin
                    n_we = 1;
                    e_addr = q_addr.pop_front();
                    e_wdata = q_data.pop_front();
                    n_ready = 0;
                end else if (e_we) begin
                    if (m_last_pending) begin n_start = 1; m_last_pending = 0; end
                    else n_ready = 1;
                end else if (e_start) begin
                    m_waiting = 1;
                end else if (m_waiting && core_done) begin
                    e_digit = core_digit;
                    n_dv = 1;
                    n_ready = 1;
                    m_waiting = 0;
                    m_byte = 0;
                end
            end
            e_rstc = 0;
            e_ready = n_ready; e_we = n_we; e_start = n_start; e_dv = n_dv;
            e_busy = !n_ready;
        end
    end

    // ---------------- core responder ----------------
    int         resp_lat = 20, resp_hold = 1, wait_cnt = 0, hold_cnt = 0;
    logic [3:0] resp_digit = 4'd7;
    bit         noise_en = 0;

    initial begin
        core_done = 0; core_digit = 0;
        forever begin
            @(posedge clk); #1;
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) core_done = 0;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    core_done = 1; core_digit = resp_digit; hold_cnt = resp_hold;
                end
            end else if (start === 1'b1) begin
                wait_cnt = resp_lat; core_done = 0;
            end else begin
                core_done = noise_en ? 1'($urandom) : 1'b0;
                core_digit = 4'($urandom);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit garble = 0;

    task automatic idle(input int n);
        rx_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1;
        while (rx_ready !== 1'b1 && t < 300) begin
            rx_data = garble ? 8'($urandom) : b;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("handshake_timeout", 32'(t), 32'(0));
        else begin
            rx_data = b;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_dv(input bit hold_valid);
        int t = 0;
        int d0 = dv_seen;
        while (digit_valid !== 1'b1 && t < 400) begin
            if (hold_valid) begin rx_valid = 1; rx_data = 8'($urandom); end
            @(posedge clk); #1;
            t++;
        end
        rx_valid = 0;
        chk("dv_timeout", 32'(t < 400), 32'(1));
        @(posedge clk); #1;
        chk("dv_pulses", 32'(dv_seen - d0), 32'(1));
    endtask

    task automatic do_reset(input int n);
        rx_valid = 0;
        rst = 1;
        repeat (n) begin @(posedge clk); #1; end
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int mark, s0, h0, bad, nbytes, exp_bytes;
        bit exp_a5[8];
        exp_a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
        rst = 1; rx_valid = 0; rx_data = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        idle(3);

        // Single byte 0xA5
        mark = wlog_a.size();
        send_byte(8'hA5);
        idle(12);
        chk("a5_count", 32'(wlog_a.size() - mark), 32'(8));
        if (wlog_a.size() >= mark + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("a5_addr", 32'(wlog_a[mark + i]), 32'(i));
                chk("a5_data", 32'(wlog_d[mark + i]), 32'(exp_a5[i]));
            end
        end

        // Full image, back-to-back, digit 7
        do_reset(2);
        mark = wlog_a.size(); s0 = starts_seen;
        resp_digit = 4'd7; resp_lat = 20; resp_hold = 1;
        for (int i = 0; i < c_NBYTES; i++) send_byte(8'($urandom));
        rx_valid = 0;
        wait_dv(0);
        chk("img_starts", 32'(starts_seen - s0), 32'(1));
        chk("img_digit", 32'(digit), 32'(7));
        chk("img_writes", 32'(wlog_a.size() - mark), 32'(c_NPIX));
        bad = 0;
        for (int k = 0; k < c_NPIX && mark + k < wlog_a.size(); k++)
            if (wlog_a[mark + k] != k) bad++;
        chk("img_addr_order", 32'(bad), 32'(0));

        // Backpressure with garbage data, noisy and level core_done
        noise_en = 1; garble = 1; resp_hold = 5; resp_digit = 4'($urandom_range(0, 9));
        s0 = starts_seen; h0 = hs_seen;
        for (int i = 0; i < c_NBYTES; i++) send_byte(8'($urandom));
        wait_dv(1);
        chk("bp_handshakes", 32'(hs_seen - h0), 32'(c_NBYTES));
        chk("bp_starts", 32'(starts_seen - s0), 32'(1));
        noise_en = 0; garble = 0; resp_hold = 1;
        idle(8);

        // Reset after 50 bytes abandons the image
        s0 = starts_seen;
        for (int i = 0; i < 50; i++) send_byte(8'($urandom));
        idle(3);
        do_reset(2);
        idle(20);
        chk("rst_no_start", 32'(starts_seen - s0), 32'(0));
        mark = wlog_a.size(); s0 = starts_seen;
        resp_digit = 4'd3;
        for (int i = 0; i < c_NBYTES; i++) send_byte(8'($urandom));
        rx_valid = 0;
        wait_dv(0);
        chk("rst_starts", 32'(starts_seen - s0), 32'(1));
        if (wlog_a.size() > mark) chk("rst_first_addr", 32'(wlog_a[mark]), 32'(0));
        else chk("rst_first_addr_missing", 32'(wlog_a.size()), 32'(mark + 1));
        chk("rst_digit", 32'(digit), 32'(3));

        // 10 bytes, long idle gap, then bytes until start
        do_reset(2);
        idle(2);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        idle(c_TO + 20);
        s0 = starts_seen; nbytes = 0;
        while (starts_seen == s0 && nbytes < c_NBYTES + 5) begin
            send_byte(8'($urandom));
            idle(10);
            nbytes++;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        exp_bytes = 98;
`else
        exp_bytes = 88;
`endif
        chk("gap_bytes_to_start", 32'(nbytes), 32'(exp_bytes));
        if (starts_seen != s0) wait_dv(0);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snn_image_loader.md
Name: snn_image_loader

Overview:
- Upstream feeder for snn_core.
- Accepts a 28x28 binary image as packed bytes over a valid/ready byte stream (UART receiver side) and unpacks each byte bit-serially into the 1-bit-wide input-unit RAM.
- After the last pixel is written, pulses start to snn_core, waits for its done, then captures and presents the classified digit.

Parameters:
- NUM_PIXELS, 784, pixels per image; must be a multiple of 8.
- ADDR_W, 10, input RAM address width.
- TIMEOUT_CYC, 100000, idle clocks between bytes before the partial image is discarded (only with SNN_LOADER_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  packed pixel byte; bit0 = lowest pixel address.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- ram_we  output  1  input RAM write enable.
- ram_addr  output  ADDR_W  input RAM write address.
- ram_wdata  output  1  pixel bit to write.
- start  output  1  one-cycle start pulse to snn_core.
- core_done  input  1  snn_core done.
- core_digit  input  4  snn_core digit result.
- digit  output  4  last captured digit.
- digit_valid  output  1  one-cycle pulse when digit updates.
- busy  output  1  high in every state except ACCEPT.

Behaviour:
- Reset values: rx_ready=0 in the reset cycle, then 1. ram_we=0, ram_addr=0, ram_wdata=0, start=0, digit=0, digit_valid=0, busy=0. State ACCEPT; byte and bit counters cleared.
- Reset mid-operation: the partial image is abandoned, counters are cleared and no start is issued. RAM contents are left as is.
- States and transitions:
  - ACCEPT: rx_ready=1. On rx_valid&rx_ready, latch rx_data into a shift register and go to UNPACK.
  - UNPACK: rx_ready=0. For 8 consecutive cycles drive ram_we=1, ram_addr=byte_idx*8+bit_idx, ram_wdata=shift[0], then shift right.
    - After bit 7, if byte_idx==NUM_PIXELS/8-1, go to START.
    - Otherwise increment byte_idx and return to ACCEPT.
  - START: start=1 for exactly one cycle, ram_we=0. Go to WAIT_CORE.
  - WAIT_CORE: rx_ready=0. On the first cycle core_done=1, register digit<=core_digit, pulse digit_valid for one cycle, clear counters and go to ACCEPT.
- core_done may be a level or a pulse; it is consumed once per image.
- Latency:
  - A handshake in cycle N produces writes in cycles N+1..N+8.
  - The next byte can be accepted in cycle N+9.
  - Minimum image load time is NUM_PIXELS/8*9 cycles.
  - start is asserted the cycle after the write to address NUM_PIXELS-1 (783).
- ram_addr is ADDR_W bits and never exceeds NUM_PIXELS-1. No wrap-around occurs inside an image.
- Bytes presented while rx_ready=0 are held off and not lost; the source must hold rx_valid/rx_data.
- core_done seen in ACCEPT/UNPACK/START is ignored.
- digit holds its value until the next capture.

Optional Feature:
- Macro name: SNN_LOADER_TIMEOUT_EN.
- Enabled:
  - A counter runs in ACCEPT while byte_idx!=0 and clears on each accepted byte.
  - On reaching TIMEOUT_CYC, byte_idx is reset to 0. The image restarts at address 0 and no start is issued.
  - The counter is held at 0 in all other states.
- Disabled: the counter is not built. A partial image waits indefinitely for the remaining bytes.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0 during reset; rx_ready=1 the cycle after rst falls; busy=0.
- Single byte 0xA5 at byte_idx 0 -> ram_we high for 8 cycles, addrs 0..7, wdata 1,0,1,0,0,1,0,1; rx_ready=0 during those cycles.
- Full image: 98 back-to-back bytes with rx_valid held high -> 784 writes with addrs 0..783 in order, exactly one start pulse one cycle after the addr 783 write. Model core_done after 20 cycles with core_digit=7 -> digit=7, one-cycle digit_valid, rx_ready=1 the next cycle.
- Backpressure: rx_valid held high with changing data during UNPACK and WAIT_CORE -> no bytes accepted; the byte count matches handshakes only.
- Reset asserted after 50 bytes -> no start pulse; the next 98 bytes write from address 0 and produce a start.
- With SNN_LOADER_TIMEOUT_EN and TIMEOUT_CYC=100: send 10 bytes, idle 100 cycles, send 98 bytes -> the first of the 98 writes address 0 and a single start follows. Without the macro, the same stimulus gives start after 88 bytes.
